// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with front-end stall/flush execution.
// Latches the fetched PC/instruction and exposes register-address fields for the
// load-use hazard detector. It applies the detector's registered stall by freezing
// the PC and IF/ID and bubbling ID/EX. A taken-branch flush squashes IF/ID.
// Saturating counters record how many cycles were stalled and how many were flushed.
module if_id_stage_reg #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 6,
  parameter int unsigned CNT_W      = 16,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       pc_IF,
  input  logic [31:0]           instr_IF,
  input  logic                  instr_valid_IF,
  input  logic                  stall,
  input  logic                  flush,
  output logic [XLEN-1:0]       pc_IF_ID,
  output logic [31:0]           instr_IF_ID,
  output logic                  valid_IF_ID,
  output logic [REG_ADDR_W-1:0] rs1_IF_ID,
  output logic [REG_ADDR_W-1:0] rs2_IF_ID,
  output logic [REG_ADDR_W-1:0] rd_IF_ID,
  output logic                  pc_write,
  output logic                  bubble_ID_EX,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  // Stall only takes effect when no flush is present; flush always wins.
  logic stall_applied;
  logic flush_applied;

  // Qualify the incoming hazard controls with reset.
  always_comb begin
    stall_applied = ~rst & stall & ~flush;
    flush_applied = ~rst & flush;
  end

  // Front-end enables: PC advances unless stalled, and ID/EX gets a bubble on
  // reset, stall or flush (a flush also squashes the instruction sitting in ID).
  always_comb begin
    pc_write     = ~rst & (flush | ~stall);
    bubble_ID_EX = rst | (stall & ~flush) | flush;
  end

  // IF/ID register: reset > flush > stall > normal capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_IF_ID    <= '0;
      instr_IF_ID <= NOP_INSTR;
      valid_IF_ID <= 1'b0;
    end else if (flush) begin
      instr_IF_ID <= NOP_INSTR;
      valid_IF_ID <= 1'b0;
    end else if (!stall) begin
      pc_IF_ID    <= pc_IF;
      instr_IF_ID <= instr_valid_IF ? instr_IF : NOP_INSTR;
      valid_IF_ID <= instr_valid_IF;
    end
  end

  // Register-address fields decoded straight off the IF/ID register.
  always_comb begin
    rs1_IF_ID = REG_ADDR_W'(instr_IF_ID[19:15]);
    rs2_IF_ID = REG_ADDR_W'(instr_IF_ID[24:20]);
    rd_IF_ID  = REG_ADDR_W'(instr_IF_ID[11:7]);
  end

  // Saturating performance counters; they stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_applied && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (flush_applied && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Testbench for if_id_stage_reg: directed vector table, counter saturation and
// reset-during-stall sequence, then randomized traffic against a behavioural model.
module tb_if_id_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, iv;
  logic [31:0] pc_in, instr_in;

  // Main instance (CNT_W = 16)
  logic [31:0] pc_o, instr_o;
  logic        v_o, pcw_o, bub_o;
  logic [5:0]  rs1_o, rs2_o, rd_o;
  logic [15:0] sc_o, fc_o;

  // Narrow-counter instance (CNT_W = 3) for saturation
  logic [31:0] s_pc_o, s_instr_o;
  logic        s_v_o, s_pcw_o, s_bub_o;
  logic [5:0]  s_rs1_o, s_rs2_o, s_rd_o;
  logic [2:0]  s_sc_o, s_fc_o;

  int tests  = 0;
  int failed = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr;
  logic        m_v;
  int          m_sc, m_fc;

  if_id_stage_reg #(.XLEN(32), .REG_ADDR_W(6), .CNT_W(16), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc_IF(pc_in), .instr_IF(instr_in), .instr_valid_IF(iv),
    .stall(stall), .flush(flush), .pc_IF_ID(pc_o), .instr_IF_ID(instr_o),
    .valid_IF_ID(v_o), .rs1_IF_ID(rs1_o), .rs2_IF_ID(rs2_o), .rd_IF_ID(rd_o),
    .pc_write(pcw_o), .bubble_ID_EX(bub_o), .stall_count(sc_o), .flush_count(fc_o)
  );

  if_id_stage_reg #(.XLEN(32), .REG_ADDR_W(6), .CNT_W(3), .NOP_INSTR(NOP)) dut_sat (
    .clk(clk), .rst(rst), .pc_IF(pc_in), .instr_IF(instr_in), .instr_valid_IF(iv),
    .stall(stall), .flush(flush), .pc_IF_ID(s_pc_o), .instr_IF_ID(s_instr_o),
    .valid_IF_ID(s_v_o), .rs1_IF_ID(s_rs1_o), .rs2_IF_ID(s_rs2_o), .rd_IF_ID(s_rd_o),
    .pc_write(s_pcw_o), .bubble_ID_EX(s_bub_o), .stall_count(s_sc_o), .flush_count(s_fc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, flush, iv;
    logic [31:0] pc, instr;
    logic        e_pcw, e_bub;
    logic [31:0] e_pc, e_instr;
    logic        e_v;
    logic [5:0]  e_rs1, e_rs2, e_rd;
    int          e_sc, e_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned satv(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? longint'(mx) : longint'(v);
  endfunction

  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] p, input logic [31:0] i);
    rst = r; stall = s; flush = f; iv = v; pc_in = p; instr_in = i;
    #1;
  endtask

  // Advance one clock edge; the model applies the same edge's rules to its state.
  task automatic tick();
    if (rst) begin
      m_pc = '0; m_instr = NOP; m_v = 1'b0; m_sc = 0; m_fc = 0;
    end else if (flush) begin
      m_instr = NOP; m_v = 1'b0; m_fc = m_fc + 1;
    end else if (stall) begin
      m_sc = m_sc + 1;
    end else begin
      m_pc = pc_in; m_v = iv; m_instr = iv ? instr_in : NOP;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_comb(input string tag);
    logic e_pcw, e_bub;
    e_pcw = !rst && (flush || !stall);
    e_bub = rst || stall || flush;
    chk({tag, ".pc_write"}, 64'(pcw_o), 64'(e_pcw));
    chk({tag, ".bubble"}, 64'(bub_o), 64'(e_bub));
    chk({tag, ".sat.pc_write"}, 64'(s_pcw_o), 64'(e_pcw));
    chk({tag, ".sat.bubble"}, 64'(s_bub_o), 64'(e_bub));
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 64'(pc_o), 64'(m_pc));
    chk({tag, ".instr"}, 64'(instr_o), 64'(m_instr));
    chk({tag, ".valid"}, 64'(v_o), 64'(m_v));
    chk({tag, ".rs1"}, 64'(rs1_o), 64'(m_instr[19:15]));
    chk({tag, ".rs2"}, 64'(rs2_o), 64'(m_instr[24:20]));
    chk({tag, ".rd"}, 64'(rd_o), 64'(m_instr[11:7]));
    chk({tag, ".stall_count"}, 64'(sc_o), satv(m_sc, 16));
    chk({tag, ".flush_count"}, 64'(fc_o), satv(m_fc, 16));
    chk({tag, ".sat.pc"}, 64'(s_pc_o), 64'(m_pc));
    chk({tag, ".sat.instr"}, 64'(s_instr_o), 64'(m_instr));
    chk({tag, ".sat.valid"}, 64'(s_v_o), 64'(m_v));
    chk({tag, ".sat.rs1"}, 64'(s_rs1_o), 64'(m_instr[19:15]));
    chk({tag, ".sat.rs2"}, 64'(s_rs2_o), 64'(m_instr[24:20]));
    chk({tag, ".sat.rd"}, 64'(s_rd_o), 64'(m_instr[11:7]));
    chk({tag, ".sat.stall_count"}, 64'(s_sc_o), satv(m_sc, 3));
    chk({tag, ".sat.flush_count"}, 64'(s_fc_o), satv(m_fc, 3));
  endtask

  task automatic add_vec(input logic r, input logic s, input logic f, input logic v,
                         input logic [31:0] p, input logic [31:0] i,
                         input logic pcw, input logic bub,
                         input logic [31:0] ep, input logic [31:0] ei, input logic ev,
                         input logic [5:0] r1, input logic [5:0] r2, input logic [5:0] rd,
                         input int esc, input int efc);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.iv = v; t.pc = p; t.instr = i;
    t.e_pcw = pcw; t.e_bub = bub; t.e_pc = ep; t.e_instr = ei; t.e_v = ev;
    t.e_rs1 = r1; t.e_rs2 = r2; t.e_rd = rd; t.e_sc = esc; t.e_fc = efc;
    vecs.push_back(t);
  endtask

  initial begin
    m_pc = '0; m_instr = NOP; m_v = 1'b0; m_sc = 0; m_fc = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);

    //       rst  stl  fl   iv   pc            instr          pcw  bub  e_pc          e_instr        v    rs1 rs2 rd  sc fc
    add_vec(1'b1,1'b1,1'b1,1'b1, 32'h55,       32'hDEADBEEF,  1'b0,1'b1, 32'h0,       NOP,           1'b0, 0,  0,  0, 0, 0);
    add_vec(1'b1,1'b1,1'b1,1'b1, 32'h55,       32'hDEADBEEF,  1'b0,1'b1, 32'h0,       NOP,           1'b0, 0,  0,  0, 0, 0);
    add_vec(1'b0,1'b0,1'b0,1'b1, 32'h100,      32'h00A30293,  1'b1,1'b0, 32'h100,     32'h00A30293,  1'b1, 6, 10,  5, 0, 0);
    add_vec(1'b0,1'b0,1'b0,1'b1, 32'h104,      32'h00628333,  1'b1,1'b0, 32'h104,     32'h00628333,  1'b1, 5,  6,  6, 0, 0);
    add_vec(1'b0,1'b1,1'b0,1'b1, 32'h108,      32'h12345678,  1'b0,1'b1, 32'h104,     32'h00628333,  1'b1, 5,  6,  6, 1, 0);
    add_vec(1'b0,1'b0,1'b0,1'b1, 32'h108,      32'h12345678,  1'b1,1'b0, 32'h108,     32'h12345678,  1'b1, 8,  3, 12, 1, 0);
    add_vec(1'b0,1'b0,1'b1,1'b1, 32'h10C,      32'h00A30293,  1'b1,1'b1, 32'h108,     NOP,           1'b0, 0,  0,  0, 1, 1);
    add_vec(1'b0,1'b1,1'b1,1'b1, 32'h110,      32'h00628333,  1'b1,1'b1, 32'h108,     NOP,           1'b0, 0,  0,  0, 1, 2);
    add_vec(1'b0,1'b0,1'b0,1'b0, 32'h114,      32'hFFFFFFFF,  1'b1,1'b0, 32'h114,     NOP,           1'b0, 0,  0,  0, 1, 2);
    add_vec(1'b0,1'b0,1'b0,1'b1, 32'h118,      32'hFFFFFFFF,  1'b1,1'b0, 32'h118,     32'hFFFFFFFF,  1'b1,31, 31, 31, 1, 2);
    add_vec(1'b1,1'b1,1'b0,1'b1, 32'h11C,      32'h00A30293,  1'b0,1'b1, 32'h0,       NOP,           1'b0, 0,  0,  0, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].stall, vecs[k].flush, vecs[k].iv, vecs[k].pc, vecs[k].instr);
      chk($sformatf("v%0d.pc_write", k), 64'(pcw_o), 64'(vecs[k].e_pcw));
      chk($sformatf("v%0d.bubble", k), 64'(bub_o), 64'(vecs[k].e_bub));
      tick();
      chk($sformatf("v%0d.pc", k), 64'(pc_o), 64'(vecs[k].e_pc));
      chk($sformatf("v%0d.instr", k), 64'(instr_o), 64'(vecs[k].e_instr));
      chk($sformatf("v%0d.valid", k), 64'(v_o), 64'(vecs[k].e_v));
      chk($sformatf("v%0d.rs1", k), 64'(rs1_o), 64'(vecs[k].e_rs1));
      chk($sformatf("v%0d.rs2", k), 64'(rs2_o), 64'(vecs[k].e_rs2));
      chk($sformatf("v%0d.rd", k), 64'(rd_o), 64'(vecs[k].e_rd));
      chk($sformatf("v%0d.stall_count", k), 64'(sc_o), 64'(vecs[k].e_sc));
      chk($sformatf("v%0d.flush_count", k), 64'(fc_o), 64'(vecs[k].e_fc));
      chk($sformatf("v%0d.sat.stall_count", k), 64'(s_sc_o), 64'(vecs[k].e_sc));
      chk($sformatf("v%0d.sat.flush_count", k), 64'(s_fc_o), 64'(vecs[k].e_fc));
    end

    // Held stall: IF/ID frozen, narrow counter saturates at 7 and stays there.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h00A30293);
    tick();
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h300 + 32'(k), 32'h00628333);
      check_comb($sformatf("hold%0d", k));
      tick();
      chk($sformatf("hold%0d.sat.stall_count", k), 64'(s_sc_o), 64'(k > 7 ? 7 : k));
      chk($sformatf("hold%0d.stall_count", k), 64'(sc_o), 64'(k));
      chk($sformatf("hold%0d.pc", k), 64'(pc_o), 64'h200);
      chk($sformatf("hold%0d.instr", k), 64'(instr_o), 64'h00A30293);
    end
    // Repeated flushes saturate the narrow flush counter.
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 32'h400, 32'h00628333);
      check_comb($sformatf("fl%0d", k));
      tick();
      chk($sformatf("fl%0d.sat.flush_count", k), 64'(s_fc_o), 64'(k > 7 ? 7 : k));
      chk($sformatf("fl%0d.sat.stall_count", k), 64'(s_sc_o), 64'd7);
      chk($sformatf("fl%0d.valid", k), 64'(v_o), 64'd0);
    end
    // Reset in the middle of a stall returns everything to reset values.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 32'h12345678);
    check_comb("rst_mid");
    tick();
    chk("rst_mid.sat.stall_count", 64'(s_sc_o), 64'd0);
    chk("rst_mid.sat.flush_count", 64'(s_fc_o), 64'd0);
    chk("rst_mid.pc", 64'(pc_o), 64'd0);
    chk("rst_mid.instr", 64'(instr_o), 64'(NOP));
    check_all("rst_mid");

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
            $urandom, $urandom);
      check_comb($sformatf("rnd%0d", n));
      tick();
      check_all($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
